// File: rtl/subcarrier_mapper.sv
// OFDM subcarrier mapper: buffers QAM symbols and emits 64-bin frames
// (DC null, 8 BPSK pilots, 55 data bins) with an inter-frame gap.
module subcarrier_mapper #(
  parameter int WIDTH      = 16,
  parameter int FIFO_AW    = 6,
  parameter int PILOT_AMP  = 8192,
  parameter int GAP_CYCLES = 16
) (
  input  logic               map_clk,
  input  logic               map_rst_n,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [WIDTH-1:0]   map_real_din,
  input  logic [WIDTH-1:0]   map_imag_din,
  output logic               dout_valid,
  output logic [5:0]         dout_index,
  output logic [WIDTH-1:0]   map_real_dout,
  output logic [WIDTH-1:0]   map_imag_dout,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int NDATA = 55;
  localparam int GW    = $clog2(GAP_CYCLES + 1);

  localparam logic [FIFO_AW:0] CNT_FULL = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] CNT_GO   = (FIFO_AW+1)'(NDATA);
  localparam logic [WIDTH-1:0] P_POS    = WIDTH'(PILOT_AMP);
  localparam logic [WIDTH-1:0] P_NEG    = WIDTH'(-PILOT_AMP);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } state_e;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;

  state_e       state_q;
  logic [5:0]   bin_q;
  logic [GW-1:0] gap_q;
  logic [6:0]   lfsr_q;
  logic         pol_q;
  logic         lfsr_fb;

  logic push, pop, is_pilot;

  assign din_ready  = (cnt_q < CNT_FULL);
  assign push       = din_valid && din_ready;
  assign is_pilot   = (bin_q[2:0] == 3'd4);
  assign pop        = (state_q == FRAME) && (bin_q != 6'd0) && !is_pilot;
  assign fifo_count = cnt_q;
  assign lfsr_fb    = lfsr_q[6] ^ lfsr_q[3];

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Symbol storage; contents need no reset since pointers gate reads.
  always_ff @(posedge map_clk) begin
    if (push) mem_q[wptr_q] <= {map_real_din, map_imag_din};
  end

  // FIFO pointers and occupancy counter.
  always_ff @(posedge map_clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  // Frame sequencer with registered bin outputs and pilot polarity LFSR.
  always_ff @(posedge map_clk or negedge map_rst_n) begin
    if (!map_rst_n) begin
      state_q       <= IDLE;
      bin_q         <= '0;
      gap_q         <= '0;
      lfsr_q        <= 7'h7f;
      pol_q         <= 1'b0;
      dout_valid    <= 1'b0;
      dout_index    <= '0;
      map_real_dout <= '0;
      map_imag_dout <= '0;
    end else begin
      dout_valid    <= 1'b0;
      dout_index    <= '0;
      map_real_dout <= '0;
      map_imag_dout <= '0;
      unique case (state_q)
        IDLE: begin
          if (cnt_q >= CNT_GO) begin
            state_q <= FRAME;
            bin_q   <= '0;
            pol_q   <= lfsr_fb;
            lfsr_q  <= {lfsr_q[5:0], lfsr_fb};
          end
        end
        FRAME: begin
          dout_valid <= 1'b1;
          dout_index <= bin_q;
          if (is_pilot) begin
            map_real_dout <= pol_q ? P_NEG : P_POS;
          end else if (bin_q != 6'd0) begin
            {map_real_dout, map_imag_dout} <= mem_q[rptr_q];
          end
          bin_q <= bin_q + 1'b1;
          if (bin_q == 6'd63) begin
            state_q <= GAP;
            gap_q   <= '0;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) state_q <= IDLE;
          else                   gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_subcarrier_mapper.sv
// Bench for subcarrier_mapper: queue-based frame model plus
// directed vector tables for reset, latency, full FIFO and abort.
module tb_subcarrier_mapper;

  logic        clk;
  logic        rst_n;
  logic        din_valid;
  logic        din_ready;
  logic [15:0] rin, iin;
  logic        dout_valid;
  logic [5:0]  didx;
  logic [15:0] rout, iout;
  logic [6:0]  fcnt;

  subcarrier_mapper dut (
    .map_clk       (clk),
    .map_rst_n     (rst_n),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .map_real_din  (rin),
    .map_imag_din  (iin),
    .dout_valid    (dout_valid),
    .dout_index    (didx),
    .map_real_dout (rout),
    .map_imag_dout (iout),
    .fifo_count    (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int q_re[$];
  int q_im[$];
  int exp_idx, inval_run, frames, tot_frames;
  int lfsr, prev_cnt, er, ei, pl;
  bit have_prev, mon_ok, exact_gap, frame_pol, push_e, db;
  int pol_log[16];
  int cap_re[64];
  int cap_im[64];

  initial begin
    tot_frames = 0;
    exact_gap  = 0;
  end

  // Record accepted symbols using pre-edge handshake values.
  always @(posedge clk) begin
    push_e = rst_n && din_valid && din_ready;
    if (push_e) begin
      q_re.push_back(int'($signed(rin)));
      q_im.push_back(int'($signed(iin)));
    end
  end

  // Output monitor: frame layout, pilots, gaps, occupancy.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_re.delete();
      q_im.delete();
      exp_idx   = 0;
      inval_run = 0;
      frames    = 0;
      have_prev = 0;
      lfsr      = 127;
      mon_ok    = 0;
    end else begin
      db = dout_valid && didx != 0 && didx[2:0] != 3'd4;
      if (mon_ok)
        chk("fifo_count", int'(fcnt), prev_cnt + int'(push_e) - int'(db));
      chk("din_ready", int'(din_ready), int'(fcnt < 7'd64));
      if (dout_valid) begin
        if (exp_idx == 0) begin
          if (have_prev) begin
            if (exact_gap) chk("gap_exact", inval_run, 17);
            else           chk("gap_min", int'(inval_run >= 17), 1);
          end
          pl = ((lfsr >> 6) ^ (lfsr >> 3)) & 1;
          lfsr = ((lfsr << 1) | pl) & 127;
          frame_pol = pl[0];
        end
        chk("dout_index", int'(didx), exp_idx);
        er = 0;
        ei = 0;
        if (exp_idx == 0) begin
          er = 0;
        end else if (exp_idx % 8 == 4) begin
          er = frame_pol ? -8192 : 8192;
          if (exp_idx == 4 && frames < 16)
            pol_log[frames] = int'($signed(rout) < 0);
        end else if (q_re.size() == 0) begin
          chk("underflow", 1, 0);
        end else begin
          er = q_re.pop_front();
          ei = q_im.pop_front();
        end
        chk("bin_real", int'($signed(rout)), er);
        chk("bin_imag", int'($signed(iout)), ei);
        cap_re[exp_idx] = int'($signed(rout));
        cap_im[exp_idx] = int'($signed(iout));
        exp_idx++;
        if (exp_idx == 64) begin
          exp_idx   = 0;
          frames++;
          tot_frames++;
          have_prev = 1;
          inval_run = 0;
        end
      end else begin
        chk("frame_break", exp_idx, 0);
        exp_idx = 0;
        chk("idle_zero", int'(rout | iout | 16'(didx)), 0);
        inval_run++;
      end
      prev_cnt = int'(fcnt);
      mon_ok   = 1;
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input int re, input int im);
    int g;
    din_valid = 1'b1;
    rin = 16'(re);
    iin = 16'(im);
    g = 0;
    while (!din_ready && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("send_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c;
    c = 0;
    while (tot_frames < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("frame_wait", int'(tot_frames >= target), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    int k;
    int re;
    int im;
  } vec_t;

  vec_t tab[11];
  int   sgn[7];
  int   base, g;
  bit   seen_full;

  initial begin
    tab[0]  = '{0, 0, 0};
    tab[1]  = '{1, 1, -1};
    tab[2]  = '{3, 3, -3};
    tab[3]  = '{4, 8192, 0};
    tab[4]  = '{5, 4, -4};
    tab[5]  = '{11, 10, -10};
    tab[6]  = '{12, 8192, 0};
    tab[7]  = '{13, 11, -11};
    tab[8]  = '{60, 8192, 0};
    tab[9]  = '{61, 53, -53};
    tab[10] = '{63, 55, -55};
    sgn = '{0, 0, 0, 0, 1, 1, 1};

    rst_n = 1'b0;
    din_valid = 1'b0;
    rin = '0;
    iin = '0;

    // 1: reset values, then quiet with no input
    #23;
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_index", int'(didx), 0);
    chk("rst_real", int'(rout), 0);
    chk("rst_imag", int'(iout), 0);
    chk("rst_ready", int'(din_ready), 1);
    chk("rst_count", int'(fcnt), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("t1_quiet", int'(dout_valid), 0);
    end

    // 2: one ramp frame checked against the bin table
    base = tot_frames;
    for (int n = 1; n <= 55; n++) send(n, -n);
    din_valid = 1'b0;
    wait_frames(base + 1, 300);
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("t2_re_bin%0d", tab[i].k), cap_re[tab[i].k], tab[i].re);
      chk($sformatf("t2_im_bin%0d", tab[i].k), cap_im[tab[i].k], tab[i].im);
    end
    @(negedge clk);
    chk("t2_after_valid", int'(dout_valid), 0);
    chk("t2_after_count", int'(fcnt), 0);

    // 3: 54 symbols hold off the frame; the 55th starts it 2 edges later
    repeat (20) @(negedge clk);
    for (int n = 1; n <= 54; n++) send(n, -n);
    din_valid = 1'b0;
    repeat (30) begin
      @(negedge clk);
      chk("t3_no_frame", int'(dout_valid), 0);
    end
    send(55, -55);
    din_valid = 1'b0;
    chk("t3_lat0", int'(dout_valid), 0);
    @(negedge clk);
    chk("t3_lat1", int'(dout_valid), 0);
    @(negedge clk);
    chk("t3_lat2", int'(dout_valid), 1);
    chk("t3_lat2_idx", int'(didx), 0);
    wait_frames(tot_frames + 1, 200);

    // 4: seven streamed frames, exact gaps, pilot signs
    do_reset();
    exact_gap = 1'b1;
    base = tot_frames;
    for (int n = 0; n < 7 * 55; n++)
      send(int'($urandom_range(0, 65535)) - 32768,
           int'($urandom_range(0, 65535)) - 32768);
    din_valid = 1'b0;
    wait_frames(base + 7, 2000);
    exact_gap = 1'b0;
    for (int f = 0; f < 7; f++)
      chk($sformatf("t4_pilot_sign%0d", f), pol_log[f], sgn[f]);
    chk("t4_drained", int'(fcnt), 0);

    // 5: unstalled upstream fills the FIFO to 64
    seen_full = 1'b0;
    for (int i = 0; i < 400 && !seen_full; i++) begin
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      if (fcnt == 7'd64) seen_full = 1'b1;
    end
    chk("t5_seen_full", int'(seen_full), 1);
    chk("t5_full_ready", int'(din_ready), 0);
    for (int i = 0; i < 5; i++)
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    din_valid = 1'b0;
    repeat (100) @(negedge clk);

    // 6: abort at bin 30, refill, fresh frame with positive pilot
    do_reset();
    for (int n = 0; n < 55; n++)
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    din_valid = 1'b0;
    g = 0;
    while (!(dout_valid && didx == 6'd30) && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("t6_reach30", int'(g < 300), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", int'(dout_valid), 0);
    chk("t6_index", int'(didx), 0);
    chk("t6_data", int'(rout | iout), 0);
    chk("t6_count", int'(fcnt), 0);
    chk("t6_ready", int'(din_ready), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    base = tot_frames;
    for (int n = 1; n <= 55; n++) send(100 + n, -(100 + n));
    din_valid = 1'b0;
    wait_frames(base + 1, 300);
    chk("t6_bin0", cap_re[0], 0);
    chk("t6_bin1", cap_re[1], 101);
    chk("t6_pilot", cap_re[4], 8192);
    chk("t6_bin63", cap_im[63], -155);
    chk("t6_pol", pol_log[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
